preamble_tx: RTL and testbench
==============================

# preamble_tx

Transmit-side counterpart of the receive correlator. It emits a programmed ±A BPSK/QPSK chip sequence (the preamble) on the TX I/Q sample path, one chip per `txstrobe`. It uses the same 8×32 coefficient word format and load interface as the correlator (`cdata`/`cstate`/`cwrite`), so a single host write sequence programs both the transmitter and the detector. It sits between the inband TX packet logic (which raises `start`) and the TX interpolator input.

## Interface
Parameters:
- `MAX_CHIPS`, 112, hard ceiling on sequence length (7 data words × 16 chips).

Ports:
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `txstrobe` in 1: sample-rate strobe from the TX chain.
- `start` in 1: single-cycle request to send the preamble.
- `cdata` in 32: coefficient word; [31:16] real half, [15:0] imag half.
- `cstate` in 3: coefficient word address 0..7.
- `cwrite` in 1: write `cdata` to word `cstate`.
- `i_out` out 16: signed I sample.
- `q_out` out 16: signed Q sample.
- `busy` out 1: high from the accepted `start` until `done`.
- `done` out 1: one-cycle pulse when the sequence completes.
- `debugbus` out 16: {busy, done, state[1:0], chip_idx[6:0], cwrite, cstate[2:0], txstrobe}.

## Operation
- Word 0:
  - [30:16] is the amplitude magnitude A, 15-bit unsigned. Bit 31 is ignored, so -A never overflows.
  - [6:0] is the chip count N. Values of N greater than 112 are clamped to 112.
- Words 1..7 hold chip signs. Chip k uses word 1+k/16, bit b=k%16.
  - I = cdata bit[16+b] ? +A : -A.
  - Q = cdata bit[b] ? +A : -A.
  - A sign bit of 1 means positive. This matches the correlator's sign convention.
- States:
  - IDLE: outputs are zero. `start` (with `cwrite` low) moves to LOAD0. `start` while `cwrite` is high is dropped.
  - LOAD0: read word 0. Always moves to LOAD1 on the next cycle.
  - LOAD1: latch A and N, and read word 1.
    - If N==0, pulse `done` and return to IDLE.
    - Otherwise move to SEND with chip_idx=0.
  - SEND: each `txstrobe` drives chip chip_idx onto `i_out`/`q_out` and increments chip_idx.
    - When chip_idx wraps from b=15 to b=0, the next word is fetched. It must be valid before the next strobe.
    - After chip N-1 is emitted, the next `txstrobe` drives 0/0, pulses `done`, drops `busy`, and returns to IDLE.
- `cwrite` while `busy` is ignored: the store is unchanged.
- `start` while `busy` is ignored.
- `txstrobe` in IDLE, LOAD0 or LOAD1 produces a zero output.
- Reset mid-sequence: the following all go to 0 on the next edge: state (IDLE), `i_out`, `q_out`, `busy`, `done`, chip_idx. The coefficient store contents are preserved.

## Timing
- Reset values: `i_out`=0, `q_out`=0, `busy`=0, `done`=0. `debugbus` reflects the reset state.
- `start` sampled at cycle t:
  - `busy` is high at t+1.
  - LOAD0 at t+1, LOAD1 at t+2, SEND from t+3.
- The first `txstrobe` accepted for chip 0 is at or after t+3.
- Outputs are registered: `txstrobe` at cycle s updates `i_out`/`q_out` at s+1. The values hold until the next strobe.
- `txstrobe` must be spaced at least 2 cycles apart. This allows the synchronous word prefetch.
- `done` is high for exactly the one cycle in which the zero sample appears (s+1 of the terminating strobe). `busy` falls in that same cycle.
- A `cwrite` issued at cycle w is visible to a `start` sampled at w+1 or later.

## Configuration
- `PREAMBLE_TX_RAMP_EN` defined: chip 0 and chip N-1 are emitted at ±(A>>>1).
  - The other chips use ±A.
  - When N==1, the single chip is emitted at ±(A>>>1).
- Not defined: every chip is emitted at ±A.

## Structure
- Shared package `preamble_pkg`:
  - state enum {IDLE, LOAD0, LOAD1, SEND}.
  - `COEF_WORDS`=8.
  - `CHIPS_PER_WORD`=16.
  - Word-0 field positions (amplitude [30:16], length [6:0]).
  - The correlator is to import the same field positions.
- One sub-module, `preamble_coef_ram`: 8×32 single-port store with a synchronous read and write enable. Writes are gated off by `busy` in the parent.

## Test plan
- Program word0 = {16'h0100, 16'd5} and word1 = 32'hFFFF_0000, then start. Five strobes give I=+256, Q=-256. The 6th strobe gives 0/0 with `done`=1 for one cycle and `busy`=0.
- N=20, word1 bits all 1 and word2 bits all 0. Chips 0..15 are +A/+A and chips 16..19 are -A/-A, with no gap at the word boundary at a 2-cycle strobe spacing.
- Word0 length = 127. Exactly 112 chips are emitted, then `done`.
- Word0 length = 0, then start. `done` pulses at t+2, no nonzero sample appears, and `busy` is high only at t+1..t+2.
- Reset asserted after chip 3 of 10. Next cycle all outputs are 0 and state is IDLE. A restart re-emits from chip 0 with the original coefficients.
- `cwrite` to word1 and a second `start` both issued mid-sequence: both are ignored and the sequence completes unchanged. With `PREAMBLE_TX_RAMP_EN` and A=256, the first and last chips are ±128.

Source files
------------

// File: rtl/preamble_pkg.sv
// Types and coefficient word-0 field layout shared by the preamble transmitter and the receive correlator.
package preamble_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD0 = 2'd1,
    LOAD1 = 2'd2,
    SEND  = 2'd3
  } state_t;

  localparam int COEF_WORDS     = 8;
  localparam int CHIPS_PER_WORD = 16;

  // Word 0: amplitude magnitude in [30:16] (bit 31 ignored), chip count in [6:0]
  localparam int AMP_MSB = 30;
  localparam int AMP_LSB = 16;
  localparam int LEN_MSB = 6;
  localparam int LEN_LSB = 0;
  localparam int AMP_W   = AMP_MSB - AMP_LSB + 1;
  localparam int LEN_W   = LEN_MSB - LEN_LSB + 1;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] max_len);
    return (len > max_len) ? max_len : len;
  endfunction

endpackage

// File: rtl/preamble_tx_if.sv
// TX preamble bundle: host coefficient load, start/strobe controls, and the I/Q sample outputs.
interface preamble_tx_if;
  logic               txstrobe;
  logic               start;
  logic [31:0]        cdata;
  logic [2:0]         cstate;
  logic               cwrite;
  logic signed [15:0] i_out;
  logic signed [15:0] q_out;
  logic               busy;
  logic               done;
  logic [15:0]        debugbus;

  modport master (
    output txstrobe, start, cdata, cstate, cwrite,
    input  i_out, q_out, busy, done, debugbus
  );

  modport slave (
    input  txstrobe, start, cdata, cstate, cwrite,
    output i_out, q_out, busy, done, debugbus
  );
endinterface

// File: rtl/preamble_coef_ram.sv
// 8x32 single-port coefficient store, synchronous read (data one cycle after address), write-enabled.
module preamble_coef_ram
  import preamble_pkg::*;
(
  input  logic                          clk,
  input  logic                          we_i,
  input  logic [$clog2(COEF_WORDS)-1:0] addr_i,
  input  logic [31:0]                   wdata_i,
  output logic [31:0]                   rdata_o
);

  logic [31:0] mem_q [COEF_WORDS];
  logic [31:0] rdata_q;

  // No reset: contents must survive a mid-sequence reset of the transmitter
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/preamble_tx.sv
// Emits the programmed +/-A chip sequence, one chip per txstrobe, outputs registered one cycle after the strobe.
// PREAMBLE_TX_RAMP_EN halves the amplitude of the first and last chips; strobes must be >= 2 cycles apart.
module preamble_tx
  import preamble_pkg::*;
#(
  parameter int MAX_CHIPS = 112
) (
  input logic          clk,
  input logic          reset,
  preamble_tx_if.slave bus
);

  localparam int BIT_W  = $clog2(CHIPS_PER_WORD);
  localparam int ADDR_W = $clog2(COEF_WORDS);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   chip_idx_q, chip_idx_d;
  logic [LEN_W-1:0]   n_q, n_d;
  logic [AMP_W-1:0]   a_q, a_d;
  logic signed [15:0] i_q, i_d, q_q, q_d;
  logic               done_q, done_d, done_now;
  logic               busy, done;

  logic               ram_we;
  logic [ADDR_W-1:0]  rd_addr, ram_addr;
  logic [31:0]        rdata;
  logic [15:0]        re_half, im_half;
  logic [LEN_W-1:0]   n_word;
  logic [BIT_W-1:0]   chip_bit;
  logic               ramp;
  logic signed [15:0] amp, amp_neg;

  assign busy   = (state_q != IDLE);
  assign ram_we = bus.cwrite & ~busy;

  // The word for chip_idx is addressed one cycle ahead of its strobe, which is why strobes need a gap
  always_comb begin
    rd_addr = '0;
    case (state_q)
      LOAD1:   rd_addr = ADDR_W'(1);
      SEND:    rd_addr = ADDR_W'(1) + chip_idx_q[LEN_W-1:BIT_W];
      default: rd_addr = '0;
    endcase
  end

  assign ram_addr = ram_we ? bus.cstate : rd_addr;

  preamble_coef_ram u_coef_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (bus.cdata),
    .rdata_o (rdata)
  );

  assign re_half  = rdata[31:16];
  assign im_half  = rdata[15:0];
  assign n_word   = clamp_len(rdata[LEN_MSB:LEN_LSB], LEN_W'(MAX_CHIPS));
  assign chip_bit = chip_idx_q[BIT_W-1:0];

`ifdef PREAMBLE_TX_RAMP_EN
  assign ramp = (chip_idx_q == '0) || (chip_idx_q == n_q - LEN_W'(1));
`else
  assign ramp = 1'b0;
`endif

  assign amp     = ramp ? $signed({2'b00, a_q[AMP_W-1:1]}) : $signed({1'b0, a_q});
  assign amp_neg = -amp;

  always_comb begin
    state_d    = state_q;
    chip_idx_d = chip_idx_q;
    a_d        = a_q;
    n_d        = n_q;
    i_d        = i_q;
    q_d        = q_q;
    done_d     = 1'b0;
    done_now   = 1'b0;
    case (state_q)
      IDLE: begin
        i_d        = '0;
        q_d        = '0;
        chip_idx_d = '0;
        if (bus.start && !bus.cwrite) state_d = LOAD0;
      end
      LOAD0: begin
        i_d     = '0;
        q_d     = '0;
        state_d = LOAD1;
      end
      LOAD1: begin
        i_d        = '0;
        q_d        = '0;
        a_d        = rdata[AMP_MSB:AMP_LSB];
        n_d        = n_word;
        chip_idx_d = '0;
        // An empty sequence finishes straight from LOAD1, so done comes from the word being read now
        if (n_word == '0) begin
          done_now = 1'b1;
          state_d  = IDLE;
        end else begin
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.txstrobe) begin
          if (chip_idx_q == n_q) begin
            i_d        = '0;
            q_d        = '0;
            done_d     = 1'b1;
            chip_idx_d = '0;
            state_d    = IDLE;
          end else begin
            i_d        = re_half[chip_bit] ? amp : amp_neg;
            q_d        = im_half[chip_bit] ? amp : amp_neg;
            chip_idx_d = chip_idx_q + LEN_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      chip_idx_q <= '0;
      a_q        <= '0;
      n_q        <= '0;
      i_q        <= '0;
      q_q        <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      chip_idx_q <= chip_idx_d;
      a_q        <= a_d;
      n_q        <= n_d;
      i_q        <= i_d;
      q_q        <= q_d;
      done_q     <= done_d;
    end
  end

  assign done         = done_q | done_now;
  assign bus.i_out    = i_q;
  assign bus.q_out    = q_q;
  assign bus.busy     = busy;
  assign bus.done     = done;
  assign bus.debugbus = {busy, done, 2'(state_q), chip_idx_q, bus.cwrite, bus.cstate, bus.txstrobe};

endmodule

// File: tb/tb_preamble_tx.sv
// Directed bench for preamble_tx: table of sequence/chip vectors plus hand-written multi-cycle cases.
module tb_preamble_tx;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  preamble_tx_if bus ();

  preamble_tx #(.MAX_CHIPS(112)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

`ifdef PREAMBLE_TX_RAMP_EN
  localparam bit RAMP = 1'b1;
`else
  localparam bit RAMP = 1'b0;
`endif

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] wr;   // words 3..7
    int          n;    // expected chip count
    int          k;    // chip to inspect
    int          ei;   // expected I at full amplitude
    int          eq;   // expected Q at full amplitude
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  int errors = 0;
  int checks = 0;
  int si [128];
  int sq [128];
  int nsamp;
  bit got_done;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int rampv(input int x, input bit edge_chip);
    if (RAMP && edge_chip) return (x < 0) ? -((-x) >> 1) : (x >> 1);
    return x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic prog(input logic [2:0] addr, input logic [31:0] data);
    bus.cstate = addr;
    bus.cdata  = data;
    bus.cwrite = 1'b1;
    step();
    bus.cwrite = 1'b0;
  endtask

  task automatic prog_all(input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] wr);
    prog(3'd0, w0);
    prog(3'd1, w1);
    prog(3'd2, w2);
    for (int a = 3; a < 8; a++) prog(3'(a), wr);
  endtask

  // Returns positioned in cycle t+3 (first cycle in SEND)
  task automatic start_seq();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("busy_at_t1", int'(bus.busy), 1);
    step();
    step();
  endtask

  // Strobes every second cycle, recording chips until done or the strobe budget runs out
  task automatic collect(input int max_strobes, input bit expect_done);
    nsamp    = 0;
    got_done = 1'b0;
    for (int i = 0; i < 128; i++) begin
      si[i] = 99999;
      sq[i] = 99999;
    end
    for (int s = 0; s < max_strobes && !got_done; s++) begin
      bus.txstrobe = 1'b1;
      step();
      bus.txstrobe = 1'b0;
      if (bus.done) begin
        got_done = 1'b1;
        chk("done_i_zero", int'(bus.i_out), 0);
        chk("done_q_zero", int'(bus.q_out), 0);
        chk("done_busy_low", int'(bus.busy), 0);
        step();
        chk("done_one_cycle", int'(bus.done), 0);
      end else begin
        if (nsamp < 128) begin
          si[nsamp] = int'(bus.i_out);
          sq[nsamp] = int'(bus.q_out);
        end
        nsamp++;
        step();
      end
    end
    if (expect_done) chk("done_seen", int'(got_done), 1);
  endtask

  initial begin
    vecs[0]  = '{32'h0100_0005, 32'hFFFF_0000, 32'h0, 32'h0, 5, 2, 256, -256};
    vecs[1]  = '{32'h0100_0005, 32'hFFFF_0000, 32'h0, 32'h0, 5, 0, 256, -256};
    vecs[2]  = '{32'h0100_0014, 32'hFFFF_FFFF, 32'h0, 32'h0, 20, 15, 256, 256};
    vecs[3]  = '{32'h0100_0014, 32'hFFFF_FFFF, 32'h0, 32'h0, 20, 16, -256, -256};
    vecs[4]  = '{32'h0100_0014, 32'hFFFF_FFFF, 32'h0, 32'h0, 20, 19, -256, -256};
    vecs[5]  = '{32'h8123_0003, 32'h0002_0005, 32'h0, 32'h0, 3, 1, 291, -291};
    vecs[6]  = '{32'h8123_0003, 32'h0002_0005, 32'h0, 32'h0, 3, 0, -291, 291};
    vecs[7]  = '{32'h7FFF_0002, 32'h0001_0002, 32'h0, 32'h0, 2, 0, 32767, -32767};
    vecs[8]  = '{32'h7FFF_0002, 32'h0001_0002, 32'h0, 32'h0, 2, 1, -32767, 32767};
    vecs[9]  = '{32'h0010_007F, 32'h0, 32'h0, 32'h8000_0000, 112, 111, 16, -16};
    vecs[10] = '{32'h0010_007F, 32'h0, 32'h0, 32'h8000_0000, 112, 50, -16, -16};

    reset        = 1'b1;
    bus.txstrobe = 1'b0;
    bus.start    = 1'b0;
    bus.cdata    = '0;
    bus.cstate   = '0;
    bus.cwrite   = 1'b0;
    step();
    step();

    chk("rst_i", int'(bus.i_out), 0);
    chk("rst_q", int'(bus.q_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_debugbus", int'(bus.debugbus), 0);
    reset = 1'b0;
    step();

    bus.txstrobe = 1'b1;
    step();
    bus.txstrobe = 1'b0;
    chk("idle_strobe_i", int'(bus.i_out), 0);
    chk("idle_strobe_busy", int'(bus.busy), 0);
    step();

    for (int v = 0; v < NV; v++) begin
      bit edge_chip;
      prog_all(vecs[v].w0, vecs[v].w1, vecs[v].w2, vecs[v].wr);
      start_seq();
      collect(200, 1'b1);
      edge_chip = (vecs[v].k == 0) || (vecs[v].k == vecs[v].n - 1);
      chk($sformatf("v%0d_count", v), nsamp, vecs[v].n);
      chk($sformatf("v%0d_chip%0d_i", v, vecs[v].k), si[vecs[v].k], rampv(vecs[v].ei, edge_chip));
      chk($sformatf("v%0d_chip%0d_q", v, vecs[v].k), sq[vecs[v].k], rampv(vecs[v].eq, edge_chip));
      step();
    end

    // Empty sequence: busy at t+1..t+2, done at t+2, strobes produce nothing
    prog(3'd0, 32'h0100_0000);
    bus.start    = 1'b1;
    bus.txstrobe = 1'b1;
    step();
    bus.start = 1'b0;
    chk("n0_busy_t1", int'(bus.busy), 1);
    chk("n0_done_t1", int'(bus.done), 0);
    step();
    chk("n0_busy_t2", int'(bus.busy), 1);
    chk("n0_done_t2", int'(bus.done), 1);
    chk("n0_i_t2", int'(bus.i_out), 0);
    step();
    bus.txstrobe = 1'b0;
    chk("n0_busy_t3", int'(bus.busy), 0);
    chk("n0_done_t3", int'(bus.done), 0);
    chk("n0_i_t3", int'(bus.i_out), 0);
    step();

    // Reset after chip 3 of 10; store must survive and restart begins at chip 0
    prog_all(32'h0100_000A, 32'h00FF_0F0F, 32'h0, 32'h0);
    start_seq();
    collect(4, 1'b0);
    chk("mid_state_send", int'(bus.debugbus[13:12]), 3);
    chk("mid_chip_idx", int'(bus.debugbus[11:5]), 4);
    chk("mid_chip3_i", si[3], 256);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rstmid_i", int'(bus.i_out), 0);
    chk("rstmid_q", int'(bus.q_out), 0);
    chk("rstmid_busy", int'(bus.busy), 0);
    chk("rstmid_done", int'(bus.done), 0);
    chk("rstmid_state", int'(bus.debugbus[13:12]), 0);
    chk("rstmid_chip_idx", int'(bus.debugbus[11:5]), 0);
    step();
    start_seq();
    collect(20, 1'b1);
    chk("restart_count", nsamp, 10);
    chk("restart_chip0_i", si[0], rampv(256, 1'b1));
    chk("restart_chip0_q", sq[0], rampv(256, 1'b1));
    chk("restart_chip4_q", sq[4], -256);
    chk("restart_chip9_i", si[9], rampv(-256, 1'b1));
    step();

    // cwrite and start mid-sequence are both ignored
    start_seq();
    collect(2, 1'b0);
    bus.cstate = 3'd1;
    bus.cdata  = 32'h0;
    bus.cwrite = 1'b1;
    bus.start  = 1'b1;
    step();
    bus.cwrite = 1'b0;
    bus.start  = 1'b0;
    collect(20, 1'b1);
    chk("ign_remaining", nsamp, 8);
    chk("ign_chip4_i", si[2], 256);
    chk("ign_chip4_q", sq[2], -256);
    chk("ign_busy_after", int'(bus.busy), 0);
    step();
    start_seq();
    collect(20, 1'b1);
    chk("ign_store_chip0_i", si[0], rampv(256, 1'b1));
    chk("ign_store_count", nsamp, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
